// File: rtl/knn_topk_accumulator.sv
// ---------------------------------------------------------------------------
// knn_topk_accumulator
//
// Query controller for a K-nearest-neighbour classifier. A query consists of
// i_num_batches batches, each carrying NUM_OF_DISTANCE_CALCULATORS entries
// ({label, distance}). Every accepted batch is registered and presented,
// together with the current K-smallest set, to an external combinational
// merge stage; its result is folded back into the K-smallest register on the
// following edge. After the final merge, the labels of the K survivors are
// voted on and a one-cycle o_done pulse marks the result.
//
// The block never looks at distances: all ordering comes from the merge
// stage through i_sorter_result.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start             start a query (honoured only in IDLE / DONE)
//   i_num_batches       batch count, sampled when a start is accepted
//   i_dist_valid        upstream batch valid
//   i_dist_data         incoming batch
//   o_dist_ready        batch accepted this cycle when valid is high
//   o_sorter_smallest   registered K-smallest set, to the merge stage
//   o_sorter_data       registered batch, to the merge stage
//   i_sorter_result     merged K-smallest set from the merge stage
//   o_busy              high in ACCUM, MERGE and VOTE
//   o_done              one-cycle pulse on entry to DONE
//   o_class             majority label of the K survivors
//   o_group_bits        label bit of each survivor (bit i from entry i)
// ---------------------------------------------------------------------------
module knn_topk_accumulator #(
  parameter int                       REGISTER_SIZE               = 12,
  parameter int                       K                           = 5,
  parameter int                       NUM_OF_DISTANCE_CALCULATORS = 4,
  parameter logic [REGISTER_SIZE-1:0] RST_VALUE                   = 12'd4095
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [7:0]               i_num_batches,
  input  logic                     i_dist_valid,
  input  logic [REGISTER_SIZE-1:0] i_dist_data [NUM_OF_DISTANCE_CALCULATORS-1:0],
  output logic                     o_dist_ready,
  output logic [REGISTER_SIZE-1:0] o_sorter_smallest [K-1:0],
  output logic [REGISTER_SIZE-1:0] o_sorter_data [NUM_OF_DISTANCE_CALCULATORS-1:0],
  input  logic [REGISTER_SIZE-1:0] i_sorter_result [K-1:0],
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_class,
  output logic [K-1:0]             o_group_bits
);

  localparam int LBL      = REGISTER_SIZE - 1;
  localparam int CNT_W    = $clog2(K + 1);
  localparam int MAJORITY = K / 2 + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    MERGE = 3'd2,
    VOTE  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                   state_q;
  state_t                   state_d;

  logic [7:0]               batch_cnt_p0;
  logic [7:0]               num_batches_q;
  logic                     vld_p0;
  logic [REGISTER_SIZE-1:0] data_p0 [NUM_OF_DISTANCE_CALCULATORS-1:0];
  logic [REGISTER_SIZE-1:0] smallest_p1 [K-1:0];
  logic [K-1:0]             group_bits_p2;
  logic                     class_p2;
  logic                     done_p2;

  logic                     start_ok;
  logic                     hs;
  logic                     last_batch;
  logic [K-1:0]             vote_bits;

  function automatic logic [CNT_W-1:0] popcount(input logic [K-1:0] bits);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < K; i++) begin
      n = n + CNT_W'(bits[i]);
    end
    return n;
  endfunction

  function automatic logic majority(input logic [K-1:0] bits);
    return popcount(bits) >= CNT_W'(MAJORITY);
  endfunction

  // Ready is only offered while batches remain; the last acceptance moves
  // the FSM out of ACCUM, so the counter never reaches past the latched count.
  assign o_dist_ready = (state_q == ACCUM) && (batch_cnt_p0 < num_batches_q);
  assign hs           = i_dist_valid && o_dist_ready;
  assign last_batch   = (batch_cnt_p0 == (num_batches_q - 8'd1));
  assign o_busy       = (state_q == ACCUM) || (state_q == MERGE) || (state_q == VOTE);

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          start_ok = 1'b1;
          state_d  = (i_num_batches == 8'd0) ? VOTE : ACCUM;
        end
      end
      ACCUM: begin
        if (hs && last_batch) begin
          state_d = MERGE;
        end
      end
      MERGE:   state_d = VOTE;
      VOTE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vote_bits = '0;
    for (int i = 0; i < K; i++) begin
      vote_bits[i] = smallest_p1[i][LBL];
    end
  end

  // Control: FSM state, batch counter, pending flag and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      batch_cnt_p0  <= '0;
      num_batches_q <= '0;
      vld_p0        <= 1'b0;
      done_p2       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_p2 <= (state_q == VOTE);
      if (start_ok) begin
        batch_cnt_p0  <= '0;
        num_batches_q <= i_num_batches;
        vld_p0        <= 1'b0;
      end else begin
        // A fresh handshake keeps the pending flag set so back-to-back
        // batches merge at one per cycle.
        vld_p0 <= hs;
        if (hs) begin
          batch_cnt_p0 <= batch_cnt_p0 + 8'd1;
        end
      end
    end
  end

  // Stage p0: registered batch presented to the merge stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_OF_DISTANCE_CALCULATORS; j++) begin
        data_p0[j] <= RST_VALUE;
      end
    end else if (start_ok) begin
      for (int j = 0; j < NUM_OF_DISTANCE_CALCULATORS; j++) begin
        data_p0[j] <= RST_VALUE;
      end
    end else if (hs) begin
      for (int j = 0; j < NUM_OF_DISTANCE_CALCULATORS; j++) begin
        data_p0[j] <= i_dist_data[j];
      end
    end
  end

  // Stage p1: K-smallest set, refreshed from the merge result one edge
  // after each handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        smallest_p1[i] <= RST_VALUE;
      end
    end else if (start_ok) begin
      for (int i = 0; i < K; i++) begin
        smallest_p1[i] <= RST_VALUE;
      end
    end else if (vld_p0) begin
      for (int i = 0; i < K; i++) begin
        smallest_p1[i] <= i_sorter_result[i];
      end
    end
  end

  // Stage p2: vote result, only rewritten in VOTE so it stays visible
  // across DONE and into the next query until that query votes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      group_bits_p2 <= '0;
      class_p2      <= 1'b0;
    end else if (state_q == VOTE) begin
      group_bits_p2 <= vote_bits;
      class_p2      <= majority(vote_bits);
    end
  end

  assign o_sorter_smallest = smallest_p1;
  assign o_sorter_data     = data_p0;
  assign o_group_bits      = group_bits_p2;
  assign o_class           = class_p2;
  assign o_done            = done_p2;

endmodule

// File: tb/tb_knn_topk_accumulator.sv
`timescale 1ns/1ps
module tb_knn_topk_accumulator;

  localparam int          W   = 12;
  localparam int          K   = 5;
  localparam int          N   = 4;
  localparam logic [W-1:0] RST = 12'hFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [7:0]   i_num_batches;
  logic         i_dist_valid;
  logic [W-1:0] i_dist_data [N-1:0];
  logic         o_dist_ready;
  logic [W-1:0] sorter_smallest [K-1:0];
  logic [W-1:0] sorter_data [N-1:0];
  logic [W-1:0] sorter_result [K-1:0];
  logic         o_busy;
  logic         o_done;
  logic         o_class;
  logic [K-1:0] o_group_bits;

  knn_topk_accumulator #(
    .REGISTER_SIZE(W), .K(K), .NUM_OF_DISTANCE_CALCULATORS(N), .RST_VALUE(RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_batches(i_num_batches),
    .i_dist_valid(i_dist_valid), .i_dist_data(i_dist_data),
    .o_dist_ready(o_dist_ready), .o_sorter_smallest(sorter_smallest),
    .o_sorter_data(sorter_data), .i_sorter_result(sorter_result),
    .o_busy(o_busy), .o_done(o_done), .o_class(o_class), .o_group_bits(o_group_bits)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Ordering key: distance first, then label.
  function automatic logic [W-1:0] key_of(input logic [W-1:0] v);
    return {v[W-2:0], v[W-1]};
  endfunction

  // Merge stage: pick the K smallest of current set + batch by repeated minimum.
  always_comb begin : merge_stage
    logic [W-1:0] pool [K+N];
    logic         used [K+N];
    int           best;
    for (int r = 0; r < K; r++) sorter_result[r] = '0;
    for (int i = 0; i < K; i++) pool[i] = sorter_smallest[i];
    for (int j = 0; j < N; j++) pool[K+j] = sorter_data[j];
    for (int i = 0; i < K + N; i++) used[i] = 1'b0;
    best = 0;
    for (int r = 0; r < K; r++) begin
      best = -1;
      for (int i = 0; i < K + N; i++) begin
        if (!used[i]) begin
          if (best < 0) best = i;
          else if (key_of(pool[i]) < key_of(pool[best])) best = i;
        end
      end
      sorter_result[r] = pool[best];
      used[best] = 1'b1;
    end
  end

  // Reference: top-K of everything the query ever saw, via a sorted key list.
  logic [W-1:0] cur_batches [$];

  function automatic logic [K*W-1:0] ref_topk();
    int               keys [$];
    logic [K*W-1:0]   res;
    logic [W-1:0]     k;
    res = '0;
    for (int i = 0; i < K; i++) keys.push_back(int'(key_of(RST)));
    foreach (cur_batches[i]) keys.push_back(int'(key_of(cur_batches[i])));
    keys.sort();
    for (int i = 0; i < K; i++) begin
      k = W'(keys[i]);
      res[i*W +: W] = {k[0], k[W-1:1]};
    end
    return res;
  endfunction

  function automatic logic [K*W-1:0] pack_smallest();
    logic [K*W-1:0] v;
    for (int i = 0; i < K; i++) v[i*W +: W] = sorter_smallest[i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] pack_data();
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = sorter_data[j];
    return v;
  endfunction

  typedef struct packed {
    logic [K*W-1:0] set;
    logic [K-1:0]   gb;
    logic           cls;
    logic           zero;
  } exp_t;

  exp_t exp_q [$];
  int   done_cnt   = 0;
  int   rdy_cycles = 0;
  int   last_hs    = -100;
  int   last_start = -100;

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && i_dist_valid && o_dist_ready) last_hs = cyc;
      if (rst_n && i_start && !o_busy) last_start = cyc;
      if (o_dist_ready) rdy_cycles++;
      if (o_done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 1'b0);
        check("done_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("final_set", pack_smallest(), e.set);
          check("group_bits", o_group_bits, e.gb);
          check("class", o_class, e.cls);
          check("done_latency", e.zero ? (cyc - last_start) : (cyc - last_hs),
                e.zero ? 2 : 3);
        end
      end
      prev_done = o_done;
    end
  end

  logic         last_cls = 1'b0;
  logic [K-1:0] last_gb  = '0;

  task automatic fill_random(input int nb, input int min_dist);
    cur_batches = {};
    for (int i = 0; i < nb * N; i++)
      cur_batches.push_back({1'($urandom), 11'($urandom_range(2047, min_dist))});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_dist_ready, 1'b0);
    check({tag, "_busy"},  o_busy, 1'b0);
    check({tag, "_done"},  o_done, 1'b0);
    check({tag, "_class"}, o_class, 1'b0);
    check({tag, "_gb"},    o_group_bits, '0);
    check({tag, "_smallest"}, pack_smallest(), {K{RST}});
    check({tag, "_data"},  pack_data(), {N{RST}});
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic run_query(input int nb, input int gap, input bit start_mid,
                           input bit forced, input logic [K*W-1:0] forced_set);
    exp_t e;
    int   ones, d0, r0, tries;
    e.set = forced ? forced_set : ref_topk();
    ones = 0;
    for (int i = 0; i < K; i++) begin
      e.gb[i] = e.set[i*W + W - 1];
      ones += int'(e.gb[i]);
    end
    e.cls  = (ones >= 3);
    e.zero = (nb == 0);
    exp_q.push_back(e);
    d0 = done_cnt;
    r0 = rdy_cycles;

    i_num_batches = 8'(nb);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("start_clears_smallest", pack_smallest(), {K{RST}});
    check("start_clears_data", pack_data(), {N{RST}});
    check("start_busy", o_busy, 1'b1);
    check("class_held_after_start", o_class, last_cls);
    check("gb_held_after_start", o_group_bits, last_gb);

    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < N; j++) i_dist_data[j] = cur_batches[b*N + j];
      i_dist_valid = 1'b1;
      if (start_mid && b == 0) i_start = 1'b1;
      tries = 0;
      do begin
        @(negedge clk);
        tries++;
      end while (!o_dist_ready && tries < 20);
      check("ready_seen", o_dist_ready, 1'b1);
      @(posedge clk); #1;
      i_dist_valid = 1'b0;
      i_start = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end

    tries = 0;
    while (done_cnt == d0 && tries < 600) begin
      @(negedge clk);
      tries++;
    end
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    if (gap == 0 && nb > 0) check("ready_cycles", rdy_cycles - r0, nb);
    last_cls = e.cls;
    last_gb  = e.gb;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : driver
    int d0, nb, gap;
    rst_n = 1'b1;
    i_start = 1'b0;
    i_num_batches = '0;
    i_dist_valid = 1'b0;
    for (int j = 0; j < N; j++) i_dist_data[j] = '0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_init");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single directed batch
    cur_batches = '{12'h005, 12'h803, 12'h004, 12'h802};
    run_query(1, 0, 0, 1, {12'hFFF, 12'h005, 12'h004, 12'h803, 12'h802});

    // Same three batches back-to-back, then with 2-cycle gaps
    fill_random(3, 0);
    run_query(3, 0, 0, 0, '0);
    run_query(3, 2, 0, 0, '0);

    // All-label-0 survivors, then a zero-batch query started from DONE
    cur_batches = '{12'h010, 12'h020, 12'h030, 12'h040,
                    12'h011, 12'h021, 12'h031, 12'h041};
    run_query(2, 0, 0, 0, '0);
    cur_batches = {};
    run_query(0, 0, 0, 0, '0);

    // Start pulsed during ACCUM
    fill_random(2, 0);
    run_query(2, 1, 1, 0, '0);

    // Reset in the middle of ACCUM with very small distances
    i_num_batches = 8'd3;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_dist_data[0] = 12'h801; i_dist_data[1] = 12'h801;
    i_dist_data[2] = 12'h800; i_dist_data[3] = 12'h800;
    i_dist_valid = 1'b1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    i_dist_valid = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("idle_after_abort", o_busy, 1'b0);
    last_cls = 1'b0;
    last_gb  = '0;
    @(posedge clk); #1;
    fill_random(2, 256);
    run_query(2, 0, 0, 0, '0);

    // Randomised queries
    for (int q = 0; q < 8; q++) begin
      nb  = $urandom_range(8, 1);
      gap = $urandom_range(2, 0);
      fill_random(nb, 0);
      run_query(nb, gap, 0, 0, '0);
    end

    // Maximum batch count
    fill_random(255, 0);
    run_query(255, 0, 0, 0, '0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
